// File: rtl/nand_cpu_pkg.sv
// nand_cpu_pkg: shared hazard FSM states, widths and saturating increment
`ifndef PC_SIZE
`define PC_SIZE 16
`endif
package nand_cpu_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} hazard_state_t;
  localparam int INT_CODE_W = 4;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at its maximum value instead of wrapping
module sat_counter
  import nand_cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  localparam logic [31:0] MAX = 32'({CNT_W{1'b1}});
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_w
    $error("sat_counter: CNT_W must be 1..32");
  end
  always_ff @(posedge clk)
    count <= rst ? '0 : inc ? CNT_W'(sat_inc(32'(count), MAX)) : count;
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline retain/clear, deferred redirects, halt/interrupt drain FSM and stall counters
module hazard_sequencer
  import nand_cpu_pkg::*;
#(
  parameter int NUM_REGS    = 3,
  parameter int RESOLVE_IDX = 2,
  parameter int MEM_IDX     = 2,
  parameter int PC_SIZE     = `PC_SIZE,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REGS-1:0]   reg_valid,
  input  logic [NUM_REGS-1:0]   reg_halt,
  input  logic [NUM_REGS-1:0]   reg_interrupt,
  input  logic [INT_CODE_W-1:0] int_code_last,
  input  logic                  mispredict,
  input  logic [PC_SIZE-1:0]    recovery_pc,
  input  logic                  bp_override,
  input  logic [PC_SIZE-1:0]    bp_target,
  input  logic                  i_miss,
  input  logic                  d_miss,
  output logic [NUM_REGS-1:0]   retain,
  output logic [NUM_REGS-1:0]   clear,
  output logic                  fetch_stall,
  output logic                  fetch_override,
  output logic [PC_SIZE-1:0]    fetch_target,
  output logic                  halt_out,
  output logic                  int_out,
  output logic [INT_CODE_W-1:0] int_code_out,
  output logic [CNT_W-1:0]      cnt_mispredict,
  output logic [CNT_W-1:0]      cnt_stall
);
  if (NUM_REGS < 2 || RESOLVE_IDX >= NUM_REGS || MEM_IDX >= NUM_REGS) begin : g_bad_cfg
    $error("hazard_sequencer: need NUM_REGS>=2, RESOLVE_IDX<NUM_REGS, MEM_IDX<NUM_REGS");
  end
  hazard_state_t       state, state_nx;
  logic                mp, go_drain, halt_now, int_pulse, last_halt, last_int;
  logic                pend_v;
  logic [PC_SIZE-1:0]  pend_pc;
  logic [NUM_REGS-1:0] hz_clear, flagged;
  assign mp = mispredict & reg_valid[RESOLVE_IDX];
  genvar k;
  for (k = 0; k < NUM_REGS; k++) begin : g_reg
    assign hz_clear[k] = (mp & (k < RESOLVE_IDX)) | (i_miss & (k == 0)) | (d_miss & (k == MEM_IDX));
    assign clear[k]    = rst | hz_clear[k] | ((state == HALTED) & (k == 0));
    assign retain[k]   = ~rst & d_miss & (k < MEM_IDX);
    assign flagged[k]  = reg_valid[k] & (reg_halt[k] | reg_interrupt[k]) & ~hz_clear[k];
  end
  assign last_halt = reg_valid[NUM_REGS-1] & reg_halt[NUM_REGS-1];
  assign last_int  = reg_valid[NUM_REGS-1] & reg_interrupt[NUM_REGS-1];
  always_comb begin
    go_drain  = (state == RUN) & (|flagged);
    halt_now  = (state == HALTED) | ((state == DRAIN) & last_halt);
    int_pulse = (state == DRAIN) & ~last_halt & last_int;
    state_nx  = halt_now ? HALTED
              : go_drain ? DRAIN
              : ((state == DRAIN) & (last_int | ~(|flagged))) ? RUN
              : state;
  end
  assign fetch_stall    = rst | i_miss | (state != RUN) | go_drain;
  assign fetch_override = ~rst & ~d_miss & (mp | pend_v | bp_override);
  assign fetch_target   = mp ? recovery_pc : pend_v ? pend_pc : bp_target;
  assign halt_out       = ~rst & halt_now;
  assign int_out        = ~rst & int_pulse;
  assign int_code_out   = int_out ? int_code_last : '0;
  always_ff @(posedge clk) begin
    state   <= rst ? RUN : state_nx;
    pend_v  <= rst ? 1'b0 : d_miss ? (pend_v | mp) : 1'b0;
    pend_pc <= rst ? '0 : (mp & d_miss) ? recovery_pc : pend_pc;
  end
  sat_counter #(.CNT_W(CNT_W)) u_cnt_mp (.clk(clk), .rst(rst), .inc(mp), .count(cnt_mispredict));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (.clk(clk), .rst(rst), .inc(fetch_stall), .count(cnt_stall));
endmodule
